// File: rtl/gbd_tile_ram_writer.sv
// Copies buffer blocks into an async SRAM one byte pair at a time.
// Each pair is optionally de-interleaved from 2bpp planar form.
module gbd_tile_ram_writer #(
    parameter  int ROW_BYTES = 32,
    parameter  int ROWS      = 8,
    parameter  int BLOCKS    = 16,
    parameter  int ADDR_W    = 12,
    parameter  int OFS_W     = 10,
    parameter  int TDS_CYC   = 10,
    parameter  int TWX_CYC   = 3,
    localparam int RW        = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
    input  logic              sys_clock,
    input  logic              nAnyReset,
    input  logic              block_ready,
    input  logic              pack_mode,
    output logic              buf_req,
    output logic [OFS_W-1:0]  buf_offset,
    input  logic              buf_valid,
    input  logic [7:0]        buf_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic              ram_ncs,
    output logic              ram_nwe,
    output logic              busy,
    output logic [RW-1:0]     round_idx,
    output logic              frame_done,
    output logic              overrun
);

    localparam int XW   = (ROW_BYTES > 2) ? $clog2(ROW_BYTES) : 1;
    localparam int YW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CMAX = (TDS_CYC > TWX_CYC) ? TDS_CYC : TWX_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, GAP0, WR1, GAP1, NEXT} state_t;

    state_t          state;
    logic [XW-1:0]   ix, ix_n;
    logic [YW-1:0]   iy, iy_n;
    logic [CW-1:0]   cnt;
    logic [7:0]      s0, s1;
    logic            raw;
    logic            pending;
    logic            last_pair;
    logic [ADDR_W-1:0] pair_addr;
    logic [OFS_W-1:0]  next_ofs;
    logic [7:0]      byte0, byte1;

    function automatic logic [7:0] pack_lo(input logic [7:0] a, input logic [7:0] b);
        return {a[6], a[4], a[2], a[0], b[6], b[4], b[2], b[0]};
    endfunction

    function automatic logic [7:0] pack_hi(input logic [7:0] a, input logic [7:0] b);
        return {a[7], a[5], a[3], a[1], b[7], b[5], b[3], b[1]};
    endfunction

    // byte0 is formed from the live buf_data so it can be registered in the RD1 capture cycle
    always_comb begin
        byte0 = raw ? s0 : pack_lo(s0, buf_data);
        byte1 = raw ? s1 : pack_hi(s0, s1);
        if (ix == XW'(ROW_BYTES - 2)) begin
            ix_n = '0;
            iy_n = iy + YW'(1);
        end else begin
            ix_n = ix + XW'(2);
            iy_n = iy;
        end
        last_pair = (ix == XW'(ROW_BYTES - 2)) && (iy == YW'(ROWS - 1));
        pair_addr = ADDR_W'(round_idx) * ADDR_W'(ROWS * ROW_BYTES)
                  + ADDR_W'(iy) * ADDR_W'(ROW_BYTES) + ADDR_W'(ix);
        next_ofs  = OFS_W'(iy_n) * OFS_W'(ROW_BYTES) + OFS_W'(ix_n);
    end

    always_ff @(posedge sys_clock or negedge nAnyReset) begin
        if (!nAnyReset) begin
            state      <= IDLE;
            ix         <= '0;
            iy         <= '0;
            cnt        <= '0;
            s0         <= '0;
            s1         <= '0;
            raw        <= 1'b0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            buf_req    <= 1'b0;
            buf_offset <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_ncs    <= 1'b1;
            ram_nwe    <= 1'b1;
            busy       <= 1'b0;
            round_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (block_ready && state != IDLE) begin
                if (pending) overrun <= 1'b1;
                else         pending <= 1'b1;
            end
            case (state)
                IDLE: if (block_ready || pending) begin
                    ix         <= '0;
                    iy         <= '0;
                    raw        <= pack_mode;
                    pending    <= 1'b0;
                    ram_ncs    <= 1'b0;
                    buf_offset <= '0;
                    buf_req    <= 1'b1;
                    busy       <= 1'b1;
                    state      <= RD0;
                end
                RD0: if (buf_req && buf_valid) begin
                    s0         <= buf_data;
                    buf_req    <= 1'b0;
                    buf_offset <= buf_offset + OFS_W'(1);
                    state      <= RD1;
                end
                RD1: if (buf_req && buf_valid) begin
                    s1       <= buf_data;
                    buf_req  <= 1'b0;
                    ram_addr <= pair_addr;
                    ram_data <= byte0;
                    cnt      <= '0;
                    state    <= WR0;
                end else if (!buf_req) begin
                    buf_req <= 1'b1;
                end
                WR0, WR1: if (cnt == CW'(TDS_CYC)) begin
                    ram_nwe <= 1'b1;
                    cnt     <= '0;
                    state   <= (state == WR0) ? GAP0 : GAP1;
                end else begin
                    ram_nwe <= 1'b0;
                    cnt     <= cnt + CW'(1);
                end
                GAP0: if (cnt == CW'(TWX_CYC - 1)) begin
                    ram_addr <= ram_addr + ADDR_W'(1);
                    ram_data <= byte1;
                    cnt      <= '0;
                    state    <= WR1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                GAP1: if (cnt == CW'(TWX_CYC - 1)) begin
                    cnt   <= '0;
                    state <= NEXT;
                end else begin
                    cnt <= cnt + CW'(1);
                end
                NEXT: if (last_pair) begin
                    ram_ncs <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                    if (round_idx == RW'(BLOCKS - 1)) begin
                        round_idx  <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        round_idx <= round_idx + RW'(1);
                    end
                end else begin
                    ix         <= ix_n;
                    iy         <= iy_n;
                    buf_offset <= next_ofs;
                    buf_req    <= 1'b1;
                    state      <= RD0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gbd_tile_ram_writer.sv
// Scoreboard bench for gbd_tile_ram_writer on a reduced block geometry
// with the default SRAM write timing.
module tb_gbd_tile_ram_writer;

    localparam int RB   = 8;
    localparam int NR   = 4;
    localparam int NBLK = 16;
    localparam int AW   = 12;
    localparam int OW   = 10;
    localparam int TDS  = 10;
    localparam int TWX  = 3;
    localparam int NB   = RB * NR;

    logic          sys_clock = 1'b0;
    logic          nAnyReset = 1'b0;
    logic          block_ready = 1'b0;
    logic          pack_mode = 1'b0;
    logic          buf_valid = 1'b0;
    logic [7:0]    buf_data = '0;
    logic          buf_req;
    logic [OW-1:0] buf_offset;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          ram_ncs, ram_nwe, busy, frame_done, overrun;
    logic [3:0]    round_idx;

    gbd_tile_ram_writer #(
        .ROW_BYTES(RB), .ROWS(NR), .BLOCKS(NBLK), .ADDR_W(AW),
        .OFS_W(OW), .TDS_CYC(TDS), .TWX_CYC(TWX)
    ) dut (
        .sys_clock(sys_clock), .nAnyReset(nAnyReset), .block_ready(block_ready),
        .pack_mode(pack_mode), .buf_req(buf_req), .buf_offset(buf_offset),
        .buf_valid(buf_valid), .buf_data(buf_data), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_ncs(ram_ncs), .ram_nwe(ram_nwe), .busy(busy),
        .round_idx(round_idx), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t        sb[$];
    int         n_checks = 0;
    int         n_fails = 0;
    logic [7:0] buf_mem [NB];
    int         exp_round = 0;
    int         lat = 0;
    bit         spurious = 0;
    bit         in_reset = 1;
    int         fd_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_pack(input logic [7:0] a, input logic [7:0] b,
                                            input bit raw, input int hi);
        logic [7:0] r;
        if (raw) return (hi != 0) ? b : a;
        for (int k = 0; k < 4; k++) begin
            r[4 + k] = a[2 * k + hi];
            r[k]     = b[2 * k + hi];
        end
        return r;
    endfunction

    task automatic push_block(input bit raw);
        for (int y = 0; y < NR; y++) begin
            for (int x = 0; x < RB; x += 2) begin
                int   base;
                wr_t  w;
                base   = exp_round * NB + y * RB + x;
                w.addr = AW'(base);
                w.data = ref_pack(buf_mem[y * RB + x], buf_mem[y * RB + x + 1], raw, 0);
                sb.push_back(w);
                w.addr = AW'(base + 1);
                w.data = ref_pack(buf_mem[y * RB + x], buf_mem[y * RB + x + 1], raw, 1);
                sb.push_back(w);
            end
        end
        exp_round = (exp_round + 1) % NBLK;
    endtask

    task automatic pulse_ready(input bit push, input bit raw);
        @(negedge sys_clock);
        pack_mode   = raw;
        block_ready = 1'b1;
        if (push) push_block(raw);
        @(negedge sys_clock);
        block_ready = 1'b0;
    endtask

    task automatic fill_buf();
        for (int i = 0; i < NB; i++) buf_mem[i] = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge sys_clock);
            #1;
            if (!busy && sb.size() == 0) break;
        end
        if (n >= budget) begin
            check("idle_timeout_queue", 32'(sb.size()), 0);
            check("idle_timeout_busy", 32'(busy), 0);
        end
    endtask

    // Buffer model: answers buf_req after lat extra cycles, optionally injects unrequested valids
    initial begin
        int wc = 0;
        bit delivered = 0;
        forever begin
            @(negedge sys_clock);
            buf_valid = 1'b0;
            if (!nAnyReset) begin
                wc = 0;
                delivered = 0;
            end else if (buf_req && !delivered) begin
                if (wc >= lat) begin
                    check("rd_nwe_high", 32'(ram_nwe), 1);
                    buf_valid = 1'b1;
                    buf_data  = buf_mem[int'(buf_offset) % NB];
                    delivered = 1;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                delivered = 0;
                wc = 0;
                if (!buf_req && spurious && $urandom_range(0, 2) == 0) begin
                    buf_valid = 1'b1;
                    buf_data  = 8'($urandom);
                end
            end
        end
    end

    logic          prev_nwe = 1'b1;
    logic          prev_req = 1'b0;
    logic [AW-1:0] prev_addr = '0, cur_addr = '0;
    logic [7:0]    prev_data = '0, cur_data = '0;
    int            low_cnt = 0, high_cnt = 100, req_run = 0;
    bit            stable_ok = 1;
    wr_t           e;

    always @(negedge sys_clock) begin
        if (!nAnyReset || in_reset) begin
            prev_nwe = 1'b1;
            prev_req = 1'b0;
            high_cnt = 100;
            low_cnt  = 0;
            req_run  = 0;
        end else begin
            if (frame_done) fd_count++;
            if (!ram_nwe) begin
                if (prev_nwe) begin
                    check("setup_addr", 32'(ram_addr), 32'(prev_addr));
                    check("setup_data", 32'(ram_data), 32'(prev_data));
                    check("ncs_low", 32'(ram_ncs), 0);
                    check("gap_min", 32'(high_cnt >= TWX), 1);
                    if (sb.size() == 0) begin
                        check("extra_write", 32'(sb.size()), 1);
                    end else begin
                        e = sb.pop_front();
                        check("wr_addr", 32'(ram_addr), 32'(e.addr));
                        check("wr_data", 32'(ram_data), 32'(e.data));
                    end
                    cur_addr  = ram_addr;
                    cur_data  = ram_data;
                    stable_ok = 1;
                    low_cnt   = 1;
                end else begin
                    low_cnt++;
                    if (ram_addr !== cur_addr || ram_data !== cur_data) stable_ok = 0;
                end
            end else begin
                if (!prev_nwe) begin
                    check("nwe_low_len", 32'(low_cnt), TDS);
                    check("wr_hold", 32'(stable_ok), 1);
                    high_cnt = 1;
                end else begin
                    high_cnt++;
                end
            end
            if (buf_req) begin
                req_run++;
            end else begin
                if (prev_req) check("req_len", 32'(req_run), 32'(lat + 1));
                req_run = 0;
            end
            prev_nwe = ram_nwe;
            prev_req = buf_req;
        end
        prev_addr = ram_addr;
        prev_data = ram_data;
    end

    initial begin
        int n;
        fill_buf();
        buf_mem[0] = 8'h2F;
        buf_mem[1] = 8'hF8;
        repeat (3) @(negedge sys_clock);
        check("rst_ncs", 32'(ram_ncs), 1);
        check("rst_nwe", 32'(ram_nwe), 1);
        check("rst_addr", 32'(ram_addr), 0);
        check("rst_data", 32'(ram_data), 0);
        check("rst_req", 32'(buf_req), 0);
        check("rst_ofs", 32'(buf_offset), 0);
        check("rst_round", 32'(round_idx), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovr", 32'(overrun), 0);
        nAnyReset = 1'b1;
        in_reset  = 0;

        // rounds 0/1: planar then raw on the same leading bytes
        pulse_ready(1, 0);
        wait_idle(5000);
        pulse_ready(1, 1);
        wait_idle(5000);

        // round 2: slow buffer with unrequested valid strobes
        lat = 7;
        spurious = 1;
        fill_buf();
        pulse_ready(1, 0);
        wait_idle(8000);
        lat = 0;
        spurious = 0;
        check("round_pre3", 32'(round_idx), 3);

        fill_buf();
        pulse_ready(1, 1);
        wait_idle(5000);
        check("round_after3", 32'(round_idx), 4);

        // rounds 4/5: three extra requests while busy, only one survives
        check("ovr_before", 32'(overrun), 0);
        fill_buf();
        pulse_ready(1, 0);
        repeat (20) @(negedge sys_clock);
        pulse_ready(1, 0);
        pulse_ready(0, 0);
        pulse_ready(0, 0);
        check("ovr_after", 32'(overrun), 1);
        wait_idle(10000);
        repeat (30) @(negedge sys_clock);
        check("no_third_block", 32'(busy), 0);
        check("round_after5", 32'(round_idx), 6);

        // rounds 6/7: request lands in the completion cycle
        pulse_ready(1, 1);
        for (n = 0; n < 5000; n++) begin
            @(negedge sys_clock);
            #1;
            if (sb.size() == 0) break;
        end
        for (n = 0; n < 50; n++) begin
            if (ram_nwe) break;
            @(negedge sys_clock);
        end
        repeat (TWX) @(negedge sys_clock);
        block_ready = 1'b1;
        push_block(1);
        @(negedge sys_clock);
        block_ready = 1'b0;
        check("collide_idle", 32'(busy), 0);
        @(negedge sys_clock);
        check("collide_restart", 32'(busy), 1);
        wait_idle(5000);
        check("round_after7", 32'(round_idx), 8);

        // rounds 8..15: frame wrap
        for (int b = 8; b < NBLK; b++) begin
            if (b == NBLK - 1) check("no_fd_early", 32'(fd_count), 0);
            fill_buf();
            pulse_ready(1, 1'($urandom));
            wait_idle(5000);
        end
        check("fd_count", 32'(fd_count), 1);
        check("round_wrap", 32'(round_idx), 0);
        @(negedge sys_clock);
        check("fd_one_cycle", 32'(frame_done), 0);

        // reset in the middle of a byte write
        pulse_ready(1, 0);
        for (n = 0; n < 500; n++) begin
            @(negedge sys_clock);
            if (!ram_nwe) break;
        end
        check("midwr_seen", 32'(ram_nwe), 0);
        in_reset  = 1;
        nAnyReset = 1'b0;
        #1;
        check("abort_nwe", 32'(ram_nwe), 1);
        check("abort_ncs", 32'(ram_ncs), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_req", 32'(buf_req), 0);
        check("abort_ovr", 32'(overrun), 0);
        sb.delete();
        exp_round = 0;
        repeat (2) @(negedge sys_clock);
        nAnyReset = 1'b1;
        @(negedge sys_clock);
        in_reset = 0;
        check("abort_round", 32'(round_idx), 0);
        fill_buf();
        pulse_ready(1, 0);
        wait_idle(5000);
        check("round_post_rst", 32'(round_idx), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
